// File: rtl/logic_serial_unit.sv
// Bit-serial WIDTH-bit logic unit: streams operands LSB-first through one logic_cell.
// Optional registered zero flag on out_zero when LOGIC_SERIAL_ZERO_FLAG_EN is defined.

module logic_cell (
    input  logic       a,
    input  logic       b,
    input  logic [1:0] s,
    output logic       y
);
    always_comb begin
        y = 1'b0;
        unique case (s)
            2'b00: y = a & b;
            2'b01: y = a | b;
            2'b10: y = a ^ b;
            2'b11: y = ~a;
        endcase
    end
endmodule

module logic_serial_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [1:0]       op_q;
    logic [CntW-1:0]  cnt_q;
    logic             cell_y;
    logic [WIDTH-1:0] res_next;

    logic_cell u_cell (
        .a (a_q[0]),
        .b (b_q[0]),
        .s (op_q),
        .y (cell_y)
    );

    // Cell output enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
    assign res_next = {cell_y, res_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            op_q       <= 2'b00;
            cnt_q      <= '0;
            out_result <= '0;
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
            out_zero   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        op_q    <= in_op;
                        cnt_q   <= '0;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_next;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        out_result <= res_next;
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
                        out_zero   <= (res_next == '0);
`endif
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Held low during reset so nothing is offered before the FSM is known idle.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_logic_serial_unit.sv
// Directed self-checking bench for logic_serial_unit at WIDTH=8.
// Also checks out_zero when built with LOGIC_SERIAL_ZERO_FLAG_EN.

module tb_logic_serial_unit;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       busy;
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
    logic       out_zero;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic_serial_unit #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
        ,
        .out_zero   (out_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE; lat = edges from acceptance to out_valid, -1 on timeout.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          output int lat);
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat      = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_op     = 2'b00;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready_low: got %b expected 0", in_ready);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_tests++;
        if (out_result !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out_result: got %h expected 00", out_result);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
        n_tests++;
        if (out_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_zero: got %b expected 0", out_zero);
        end
`endif
    endtask

    task automatic test_and();
        int lat;
        out_ready = 1'b1;
        run_op(8'hF0, 8'h3C, 2'b00, lat);
        n_tests++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL and_latency: got %0d expected 8", lat);
        end
        n_tests++;
        if (out_result !== 8'h30) begin
            n_fail++;
            $display("FAIL and_result: got %h expected 30", out_result);
        end
        step();
        n_tests++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            n_fail++;
            $display("FAIL and_return_idle: got %b expected 010", {out_valid, in_ready, busy});
        end
    endtask

    task automatic test_not_zero();
        int lat;
        out_ready = 1'b1;
        run_op(8'h00, 8'hAA, 2'b11, lat);
        n_tests++;
        if (lat !== 8 || out_result !== 8'hFF) begin
            n_fail++;
            $display("FAIL not_result: got lat %0d res %h expected lat 8 res ff", lat, out_result);
        end
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
        n_tests++;
        if (out_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL not_zero_flag: got %b expected 0", out_zero);
        end
`endif
        step();
        run_op(8'h0F, 8'hF0, 2'b00, lat);
        n_tests++;
        if (lat !== 8 || out_result !== 8'h00) begin
            n_fail++;
            $display("FAIL zero_result: got lat %0d res %h expected lat 8 res 00", lat, out_result);
        end
`ifdef LOGIC_SERIAL_ZERO_FLAG_EN
        n_tests++;
        if (out_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_flag: got %b expected 1", out_zero);
        end
`endif
        step();
    endtask

    task automatic test_backpressure();
        int lat;
        int extra;
        out_ready = 1'b0;
        run_op(8'hA5, 8'hFF, 2'b10, lat);
        n_tests++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL xor_latency: got %0d expected 8", lat);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                in_a     = 8'h11;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if ({out_valid, in_ready, out_result} !== {1'b1, 1'b0, 8'h5A}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got v=%b r=%b res=%h expected v=1 r=0 res=5a",
                         i, out_valid, in_ready, out_result);
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || out_result !== 8'h5A) begin
            n_fail++;
            $display("FAIL hold_release: got v=%b res=%h expected v=0 res=5a",
                     out_valid, out_result);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) extra++;
            step();
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL no_second_result: got %0d valid cycles expected 0", extra);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        int extra;
        out_ready = 1'b1;
        in_a      = 8'h0C;
        in_b      = 8'h30;
        in_op     = 2'b01;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_busy: got %b expected 1", busy);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy, in_ready, out_valid, out_result} !== {3'b010, 8'h00}) begin
            n_fail++;
            $display("FAIL midop_abort: got b=%b r=%b v=%b res=%h expected b=0 r=1 v=0 res=00",
                     busy, in_ready, out_valid, out_result);
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) extra++;
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL midop_no_valid: got %0d valid cycles expected 0", extra);
        end
        run_op(8'h81, 8'h18, 2'b01, lat);
        n_tests++;
        if (lat !== 8 || out_result !== 8'h99) begin
            n_fail++;
            $display("FAIL or_after_reset: got lat %0d res %h expected lat 8 res 99",
                     lat, out_result);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int         acc [2];
        int         nacc;
        int         nvalid;
        logic [7:0] res [2];
        logic       accept_now;
        nacc      = 0;
        nvalid    = 0;
        acc[0]    = 0;
        acc[1]    = 0;
        res[0]    = 8'h00;
        res[1]    = 8'h00;
        out_ready = 1'b1;
        in_a      = 8'hFF;
        in_b      = 8'h0F;
        in_op     = 2'b00;
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 35; cyc++) begin
            accept_now = in_valid && in_ready;
            if (accept_now) begin
                if (nacc < 2) acc[nacc] = cyc;
                nacc++;
            end
            if (out_valid) begin
                if (nvalid < 2) res[nvalid] = out_result;
                nvalid++;
            end
            step();
            if (accept_now) begin
                if (nacc == 1) begin
                    in_a  = 8'h3C;
                    in_b  = 8'hFF;
                    in_op = 2'b10;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (nacc !== 2 || (acc[1] - acc[0]) !== 10) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d accepts spacing %0d expected 2 accepts spacing 10",
                     nacc, acc[1] - acc[0]);
        end
        n_tests++;
        if (nvalid !== 2) begin
            n_fail++;
            $display("FAIL b2b_valid_cycles: got %0d expected 2", nvalid);
        end
        n_tests++;
        if (res[0] !== 8'h0F || res[1] !== 8'hC3) begin
            n_fail++;
            $display("FAIL b2b_results: got %h %h expected 0f c3", res[0], res[1]);
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_not_zero();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_serial_unit.md
# logic_serial_unit

Bit-serial N-bit logic unit. Accepts one operand pair plus a 2-bit operation over a valid/ready handshake. Streams the operands LSB-first, one bit per clock, through a single instantiated `logic_cell`, then presents the assembled WIDTH-bit result over a second valid/ready handshake. It is the sequencing stage that feeds the `logic_cell` and consumes its output, turning the combinational 1-bit cell into an N-bit unit with a multi-cycle datapath.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.

Ports (name, direction, width, meaning):
- `clk`, in, 1: the single clock; all state changes on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_valid`, in, 1: request present.
- `in_ready`, out, 1: block can accept a request.
- `in_a`, in, WIDTH: operand a.
- `in_b`, in, WIDTH: operand b.
- `in_op`, in, 2: operation, passed to the cell's `S` input.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: consumer takes the result.
- `out_result`, out, WIDTH: result register.
- `busy`, out, 1: high in SHIFT and DONE.
- `out_zero`, out, 1: present only with the macro; see Configuration.

## Operation
- Cell encoding for `S`: 00 = a AND b, 01 = a OR b, 10 = a XOR b, 11 = NOT a (b ignored).
- FSM states: IDLE, SHIFT, DONE. The FSM is in IDLE after reset.
- IDLE
  - `in_ready`=1.
  - On an edge with `in_valid`=1: capture `in_a`/`in_b` into shift registers, capture `in_op`, clear the bit counter, and go to SHIFT.
- SHIFT
  - Shift-register LSBs of a and b drive the cell; the captured op drives `S`.
  - Each edge: the cell output enters the internal result shift register at the MSB side (shift right), a/b shift right, and the counter increments.
  - On the edge that processes bit WIDTH-1: load `out_result` from the completed value and go to DONE.
- DONE
  - `out_valid`=1.
  - On an edge with `out_ready`=1, go to IDLE.
- `in_ready`=0 in SHIFT and DONE. `in_valid` and input data are ignored there and nothing is queued.
- `out_result` changes only on entry to DONE. It holds the last result indefinitely, including after return to IDLE.
- Counter width is clog2(WIDTH)+1 bits; no wrap occurs within an operation.
- The captured op and operands are immune to input changes after acceptance.

## Timing
- Reset values: `in_ready`=0 while `rst` is high, and 1 on the first cycle after release. `out_valid`=0, `out_result`=0, `busy`=0, `out_zero`=0, state=IDLE.
- Reset mid-operation, in any state, aborts:
  - The next cycle is IDLE.
  - The in-flight result is discarded and `out_valid` never asserts for it.
  - `out_result` returns to 0.
- Latency: with acceptance at edge E0, `out_valid` rises after edge E_WIDTH, i.e. WIDTH edges later.
- Throughput: with `out_ready` held at 1, the handshake occurs at E_WIDTH+1 and the earliest next acceptance at E_WIDTH+2. Minimum request spacing is WIDTH+2 cycles.
- `out_valid` stays high with `out_result` stable for as many cycles as `out_ready` is held low.
- No combinational path from any input to any output except `in_ready`/`out_valid`. Both are state decodes only and do not depend on `in_valid` or `out_ready`.

## Configuration
- Macro: `LOGIC_SERIAL_ZERO_FLAG_EN`.
- Defined:
  - `out_zero` port exists.
  - It is registered and loaded together with `out_result` as (result == 0).
  - It holds with `out_result` and resets to 0.
- Undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- Reset: `rst`=1 for 2 cycles, then release -> `in_ready`=1, `out_valid`=0, `out_result`=8'h00, `busy`=0.
- AND: a=8'hF0, b=8'h3C, op=00 -> `out_valid` rises exactly 8 edges after acceptance with `out_result`=8'h30.
- Backpressure: XOR a=8'hA5, b=8'hFF, op=10, with `out_ready`=0 for 5 cycles -> `out_result`=8'h5A stable with `out_valid`=1 throughout. A second `in_valid` pulse with a=8'h11 meanwhile is ignored (`in_ready`=0), and no second result appears.
- NOT/zero:
  - op=11, a=8'h00, b=8'hAA -> 8'hFF (`out_zero`=0 with macro).
  - AND a=8'h0F, b=8'hF0 -> 8'h00 (`out_zero`=1 with macro).
- Reset mid-op: `rst` pulsed on the 3rd SHIFT cycle of an OR -> next cycle IDLE, no `out_valid`, `out_result`=8'h00. A following OR a=8'h81, b=8'h18 -> 8'h99.
- Back-to-back: `in_valid` and `out_ready` held at 1 with two requests -> acceptance edges exactly 10 cycles apart, and `out_valid` high for exactly 1 cycle per result.
